skinny_sbox8_ti_seq: RTL
========================

# skinny_sbox8_ti_seq

Sequencer for the 3-share threshold-implementation SKINNY 8-bit S-box layer. It walks the 16 state cells of one round through a single shared, non-pipelined TI S-box instance. For each cell it loads the shares, then steps the S-box's registered AND-gadget stages one at a time, feeding each stage fresh randomness drawn through a valid/ready handshake. It sits between the round controller and the shared S-box datapath.

## Interface
Parameters:
- NCELLS, 16, cells processed per `start`.
- NSTAGES, 4, registered gadget stages per cell; each consumes one randomness word.
- RW, 22, randomness bits per stage (widest stage: and4 + and3 + and3 + and2 gadgets).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to process one S-box layer. Ignored while `busy`.
- busy  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- done  out  1  one-cycle pulse after the last cell's writeback.
- cell_idx  out  4  index of the cell being processed; drives the state-share read/write mux.
- ld_en  out  1  one-cycle load of cell `cell_idx` shares into the S-box input registers.
- stage_ce  out  NSTAGES  one-hot clock enable for S-box stage registers; all zero when no stage is evaluating.
- wr_en  out  1  one-cycle writeback of S-box output shares to cell `cell_idx`.
- rnd_in  in  RW  fresh randomness from the PRNG.
- rnd_valid  in  1  `rnd_in` is valid.
- rnd_ready  out  1  randomness consumed this cycle.
- rnd_q  out  RW  registered randomness presented to the S-box gadgets.

## Operation
- States: IDLE, LOAD, FETCH, EVAL, WB, DONE. Counters: `cell` (0..NCELLS-1) and `stg` (0..NSTAGES-1).
- IDLE: when `start` is high, clear `cell` and `stg` and go to LOAD.
- LOAD: `ld_en`=1, then go to FETCH.
- FETCH: `rnd_ready` = `rnd_valid`. When `rnd_valid` is high, latch `rnd_in` into `rnd_q` and go to EVAL. Otherwise stay in FETCH (stall), with no outputs other than `busy` asserted.
- EVAL: `stage_ce[stg]`=1 for exactly one cycle; `rnd_q` is stable during it. On exit, clear `rnd_q` to 0.
  - If `stg` < NSTAGES-1, increment `stg` and go to FETCH.
  - Otherwise go to WB.
- WB: `wr_en`=1 and `stg`=0.
  - If `cell` = NCELLS-1, go to DONE.
  - Otherwise increment `cell` and go to LOAD.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Randomness rules:
  - A randomness word is never reused across stages or cells.
  - `rnd_ready` is never high outside FETCH.
  - Each accepted word drives exactly one EVAL.
- `start` during DONE is ignored; a new layer needs `start` in IDLE.
- `cell_idx` = `cell` in every state; it is held stable from LOAD through WB.

## Timing
- Reset values: state IDLE; `busy`, `done`, `ld_en`, `wr_en`, `rnd_ready` = 0; `stage_ce` = 0; `cell_idx` = 0; `rnd_q` = 0.
- All control outputs are registered or decoded from the state register only. There is no combinational path from `start` to any output.
- Exception: `rnd_ready` is combinational on `rnd_valid`, gated by state FETCH.
- Per cell with `rnd_valid` held high: LOAD 1 + NSTAGES × (FETCH 1 + EVAL 1) + WB 1 = 10 cycles.
- Per layer: 160 cycles, then `done` in cycle 161 counted from the first LOAD. `busy` rises the cycle after `start`.
- Each cycle `rnd_valid` is low in FETCH adds exactly one cycle. No other state stalls.
- `rst` mid-operation: return to IDLE next edge; `rnd_q` is zeroed; no `wr_en` or `done` is issued.
- `rst` and `start` in the same cycle: reset wins.

## Test plan
- Reset, then `start` with `rnd_valid`=1 constantly → `busy` 1 cycle later; 16 `ld_en`, 64 `stage_ce` pulses, 16 `wr_en` with `cell_idx` 0..15; `done` at cycle 161; 64 `rnd_ready` pulses.
- `rnd_valid` toggling 1,0,1,0… with `rnd_in` = an incrementing counter → each word appears on `rnd_q` in exactly one EVAL. No value repeats, and `rnd_q` = 0 outside EVAL and the FETCH→EVAL hand-off. Layer time grows by exactly the number of low-valid FETCH cycles.
- `rnd_valid`=0 for 50 cycles during cell 3, stage 2 → FSM held in FETCH, `stage_ce`=0, `cell_idx`=3. It resumes correctly and `done` comes 50 cycles late.
- `start` pulsed again mid-layer and in the DONE cycle → ignored; exactly one `done` per accepted `start`.
- `rst` asserted during cell 7 EVAL → next cycle all outputs at reset values. A fresh `start` then completes a full 16-cell layer from `cell_idx`=0.
- `stage_ce` one-hot check across a whole layer: order 0001, 0010, 0100, 1000 per cell; never two bits set; never set in LOAD, WB or DONE.

Source files
------------

// File: rtl/skinny_sbox8_ti_seq.sv
// Sequencer for the shared 3-share TI SKINNY S-box: walks the state cells one at
// a time, stepping each registered gadget stage with a fresh randomness word.
module skinny_sbox8_ti_seq #(
    parameter int NCELLS  = 16,
    parameter int NSTAGES = 4,
    parameter int RW      = 22
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [3:0]         cell_idx,
    output logic               ld_en,
    output logic [NSTAGES-1:0] stage_ce,
    output logic               wr_en,
    input  logic [RW-1:0]      rnd_in,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    output logic [RW-1:0]      rnd_q
);

    localparam int SW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        EVAL,
        WB,
        DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      cell_reg, cell_next;
    logic [SW-1:0]   stg_reg, stg_next;
    logic [RW-1:0]   rnd_q_reg, rnd_q_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cell_reg  <= '0;
            stg_reg   <= '0;
            rnd_q_reg <= '0;
        end else begin
            state_reg <= state_next;
            cell_reg  <= cell_next;
            stg_reg   <= stg_next;
            rnd_q_reg <= rnd_q_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cell_next  = cell_reg;
        stg_next   = stg_reg;
        rnd_q_next = rnd_q_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    cell_next  = '0;
                    stg_next   = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (rnd_valid) begin
                    rnd_q_next = rnd_in;
                    state_next = EVAL;
                end
            end
            EVAL: begin
                // A word masks exactly one stage; wipe it so it cannot leak into the next.
                rnd_q_next = '0;
                if (stg_reg == SW'(NSTAGES - 1)) begin
                    state_next = WB;
                end else begin
                    stg_next   = stg_reg + 1'b1;
                    state_next = FETCH;
                end
            end
            WB: begin
                stg_next = '0;
                if (cell_reg == 4'(NCELLS - 1)) begin
                    state_next = DONE;
                end else begin
                    cell_next  = cell_reg + 4'd1;
                    state_next = LOAD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign ld_en     = (state_reg == LOAD);
    assign wr_en     = (state_reg == WB);
    assign cell_idx  = cell_reg;
    assign rnd_q     = rnd_q_reg;
    assign rnd_ready = (state_reg == FETCH) && rnd_valid;

    generate
        for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage_ce
            assign stage_ce[gi] = (state_reg == EVAL) && (stg_reg == SW'(gi));
        end
    endgenerate

endmodule
